// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pll_seq_pkg
// Description : State encoding and counter sizing helper shared by the PLL
//               reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  // Sequencer state type and encoding (3 bits covers the five states)
  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_FILTER    = 3'd2;
  localparam logic [2:0] ST_RELEASE   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  // Width of the shared length/filter/stagger counter. It has to hold the
  // largest of the three quantities it ever counts up to.
  function automatic int cnt_width(input int lock_filt, input int nch,
                                   input int stagger, input int pll_rst_len);
    int m;
    m = lock_filt;
    if (nch * stagger > m) m = nch * stagger;
    if (pll_rst_len > m)   m = pll_rst_len;
    return $clog2(m + 1);
  endfunction

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchroniser for a single asynchronous status bit,
//               with asynchronous active-low clear of both stages.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; first stage may go metastable, second stage is clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL reset / lock-qualification sequencer. Pulses the PLL
//               reset, waits for a filtered lock, then releases NCH
//               downstream active-low resets in a staggered order. Lock loss
//               or a soft restart pulls the downstream resets back in.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int PLL_RST_LEN = 16,
  parameter int TIMEOUT     = 50000,
  parameter int LOCK_FILT   = 1024,
  parameter int STAGGER     = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           lock,
  input  logic           restart,
  output logic           pll_reset,
  output logic [NCH-1:0] rst_n,
  output logic           ready,
  output logic [7:0]     retries,
  output logic [7:0]     losses
);

  localparam int CW = cnt_width(LOCK_FILT, NCH, STAGGER, PLL_RST_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] c_len_last = CW'(PLL_RST_LEN - 1);
  localparam logic [CW-1:0] c_filt     = CW'(LOCK_FILT);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  // Registered state
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [TW-1:0]  r_timer;
  logic           r_pll_reset;
  logic [NCH-1:0] r_rst_n;
  logic           r_ready;
  logic [7:0]     r_retries;
  logic [7:0]     r_losses;

  // Next-state values
  state_t         w_state_nx;
  logic [CW-1:0]  w_cnt_nx;
  logic [CW-1:0]  w_cnt_inc;
  logic [TW-1:0]  w_timer_nx;
  logic [NCH-1:0] w_rst_n_nx;
  logic [7:0]     w_retries_nx;
  logic [7:0]     w_losses_nx;
  logic           w_pll_reset_nx;
  logic           w_ready_nx;
  logic           w_lock_s;

  // Lock comes from the PLL's own clock domain; bring it into clk first
  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (lock),
    .o_q   (w_lock_s)
  );

  assign w_cnt_inc = r_cnt + CW'(1);

  // Sequencer next-state, counter and output computation
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_timer_nx   = r_timer;
    w_rst_n_nx   = r_rst_n;
    w_retries_nx = r_retries;
    w_losses_nx  = r_losses;

    if (restart) begin
      // Soft restart wins over everything, counters are kept
      w_state_nx = ST_PLL_RST;
      w_cnt_nx   = '0;
      w_timer_nx = '0;
      w_rst_n_nx = '0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_cnt >= c_len_last) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
            w_timer_nx = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end

        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            // This sample is the first of the consecutive-lock run
            w_state_nx = ST_FILTER;
            w_cnt_nx   = CW'(1);
          end else if (r_timer >= c_tmo_last) begin
            w_state_nx = ST_PLL_RST;
            w_cnt_nx   = '0;
            w_timer_nx = '0;
            if (r_retries != 8'hFF) w_retries_nx = r_retries + 8'd1;
          end else begin
            w_timer_nx = r_timer + TW'(1);
          end
        end

        ST_FILTER: begin
          if (!w_lock_s) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
            w_timer_nx = '0;
          end else if (w_cnt_inc >= c_filt) begin
            w_state_nx = ST_RELEASE;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = w_cnt_inc;
          end
        end

        ST_RELEASE: begin
          if (!w_lock_s) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
            w_timer_nx = '0;
            w_rst_n_nx = '0;
          end else if (r_rst_n[NCH-1]) begin
            w_state_nx = ST_RUN;
            w_cnt_nx   = '0;
          end else begin
            // Channel i is released when the stagger count hits i*STAGGER
            for (int i = 0; i < NCH; i++) begin
              if (r_cnt == CW'(i * STAGGER)) w_rst_n_nx[i] = 1'b1;
            end
            if (r_cnt != '1) w_cnt_nx = w_cnt_inc;
          end
        end

        ST_RUN: begin
          if (!w_lock_s) begin
            // Lock lost: fall back to waiting for lock, PLL is not reset
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = '0;
            w_timer_nx = '0;
            w_rst_n_nx = '0;
            if (r_losses != 8'hFF) w_losses_nx = r_losses + 8'd1;
          end
        end

        default: begin
          w_state_nx = ST_PLL_RST;
          w_cnt_nx   = '0;
          w_timer_nx = '0;
          w_rst_n_nx = '0;
        end
      endcase
    end

    // Channel resets may only be released while releasing or running
    if ((w_state_nx != ST_RELEASE) && (w_state_nx != ST_RUN)) w_rst_n_nx = '0;

    w_pll_reset_nx = (w_state_nx == ST_PLL_RST);
    w_ready_nx     = (w_state_nx == ST_RUN);
  end

  // State and registered outputs, asynchronously forced by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_pll_reset <= 1'b1;
      r_rst_n     <= '0;
      r_ready     <= 1'b0;
      r_retries   <= 8'd0;
      r_losses    <= 8'd0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_timer     <= w_timer_nx;
      r_pll_reset <= w_pll_reset_nx;
      r_rst_n     <= w_rst_n_nx;
      r_ready     <= w_ready_nx;
      r_retries   <= w_retries_nx;
      r_losses    <= w_losses_nx;
    end
  end

  assign pll_reset = r_pll_reset;
  assign rst_n     = r_rst_n;
  assign ready     = r_ready;
  assign retries   = r_retries;
  assign losses    = r_losses;

endmodule : pll_reset_seq
`default_nettype wire
